// File: rtl/ldr_writeback_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ldr_writeback_sequencer                                       |
// | Purpose  : Sequences ALU writeback, LDR and STR operations between the   |
// |            execute stage, the data RAM and the register file, waiting    |
// |            out the fixed RAM read latency before a load is written back. |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            start/op/memAddr/storeData/destReg  - request from execute    |
// |            ramAddr/ramWrData/ramWe/ramRe       - RAM side (registered)   |
// |            memSelect                           - WB mux, 1=RAM 0=ALU     |
// |            regWrite/regDest                    - register-file write     |
// |            busy/done/illegal                   - status (registered)     |
// |            stall                               - start & busy (comb.)    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ldr_writeback_sequencer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 4,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] storeData,
  input  logic [REG_W-1:0]  destReg,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWrData,
  output logic              ramWe,
  output logic              ramRe,
  output logic              memSelect,
  output logic              regWrite,
  output logic [REG_W-1:0]  regDest,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              stall
);

  generate
    if (RAM_LAT < 1 || RAM_LAT > 15) begin : g_bad_ram_lat
      $error("ldr_writeback_sequencer: RAM_LAT must be within 1..15");
    end
  endgenerate

  localparam logic [1:0] C_OP_ALU = 2'b00;
  localparam logic [1:0] C_OP_LDR = 2'b01;
  localparam logic [1:0] C_OP_STR = 2'b10;

  // Number of WAIT cycles between the READ cycle and the WB cycle.
  localparam logic [3:0] C_WAIT_INIT = 4'(RAM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  state_t            r_state;
  logic [3:0]        r_wait;
  logic [REG_W-1:0]  r_dest;

  assign stall = start & busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wait    <= 4'd0;
      r_dest    <= '0;
      ramAddr   <= '0;
      ramWrData <= '0;
      ramWe     <= 1'b0;
      ramRe     <= 1'b0;
      memSelect <= 1'b0;
      regWrite  <= 1'b0;
      regDest   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      // Single-cycle pulses default low every cycle.
      ramWe    <= 1'b0;
      ramRe    <= 1'b0;
      regWrite <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dest <= destReg;
            busy   <= 1'b1;
            case (op)
              C_OP_ALU: begin
                r_state   <= S_WB;
                regWrite  <= 1'b1;
                memSelect <= 1'b0;
                regDest   <= destReg;
                done      <= 1'b1;
              end
              C_OP_LDR: begin
                r_state   <= S_READ;
                ramRe     <= 1'b1;
                ramAddr   <= memAddr;
                memSelect <= 1'b1;
                r_wait    <= C_WAIT_INIT;
              end
              C_OP_STR: begin
                r_state   <= S_STORE;
                ramWe     <= 1'b1;
                ramAddr   <= memAddr;
                ramWrData <= storeData;
                done      <= 1'b1;
              end
              default: begin
                // Reserved opcode: reuse the WB state purely as the done
                // cycle, with no register or RAM activity.
                r_state <= S_WB;
                done    <= 1'b1;
                illegal <= 1'b1;
              end
            endcase
          end
        end

        S_READ: begin
          if (r_wait == 4'd0) begin
            r_state  <= S_WB;
            regWrite <= 1'b1;
            regDest  <= r_dest;
            done     <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Leave on the last WAIT cycle so WB lands RAM_LAT cycles after READ.
          if (r_wait == 4'd1) begin
            r_wait   <= 4'd0;
            r_state  <= S_WB;
            regWrite <= 1'b1;
            regDest  <= r_dest;
            done     <= 1'b1;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end

        S_STORE, S_WB: begin
          // Done cycle: any start seen here is ignored.
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ldr_writeback_sequencer.md
Name: ldr_writeback_sequencer

Overview:
- Multi-cycle controller that sequences ALU writeback, LDR and STR operations between the execute stage, the data RAM and the register file.
- Drives the writeback-source select of the RAM/ALU writeback mux (0 = ALU result, 1 = RAM read data).
- Drives RAM read/write strobes and address/data, and the register-file write enable/destination.
- Handles the fixed RAM read latency so a load result is written back only when the RAM data is valid.

Parameters:
DATA_W, 32, data path width (RAM data, store data).
ADDR_W, 8, RAM address width.
REG_W, 4, register-file index width.
RAM_LAT, 2, cycles from ramRe high to valid RAM read data; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  one clock; reset is asynchronous and active-low.
start  input  1  request; sampled only when busy=0.
op  input  2  00 ALU writeback, 01 LDR, 10 STR, 11 reserved.
memAddr  input  ADDR_W  load/store address.
storeData  input  DATA_W  STR write data.
destReg  input  REG_W  writeback destination register.
ramAddr  output  ADDR_W  RAM address (registered).
ramWrData  output  DATA_W  RAM write data (registered).
ramWe  output  1  RAM write strobe, 1-cycle pulse.
ramRe  output  1  RAM read strobe, 1-cycle pulse.
memSelect  output  1  writeback mux select; 1 = RAM, 0 = ALU.
regWrite  output  1  register-file write enable, 1-cycle pulse.
regDest  output  REG_W  register-file write index.
busy  output  1  high from the cycle after acceptance through the done cycle.
done  output  1  1-cycle completion pulse.
illegal  output  1  1-cycle pulse with done for op=11.
stall  output  1  combinational: start & busy.

Behaviour:
- States: IDLE, STORE, READ, WAIT, WB. All outputs except stall are registered.
- Reset (async, rst_n=0) clears: state=IDLE, ramAddr=0, ramWrData=0, ramWe=0, ramRe=0, memSelect=0, regWrite=0, regDest=0, busy=0, done=0, illegal=0, wait counter=0.
- Reset mid-operation aborts the operation: no regWrite, no further RAM strobes, and the in-flight RAM read is discarded.
- Acceptance: in IDLE, start=1 at edge k captures op, memAddr, storeData and destReg. Inputs are not sampled again until the operation completes.
- ALU (op=00): at cycle k+1, state WB with regWrite=1, memSelect=0, regDest=destReg, done=1, busy=1. Returns to IDLE at k+2. Latency 1.
- STR (op=10): at cycle k+1, state STORE with ramWe=1, ramAddr=memAddr, ramWrData=storeData, done=1, busy=1, regWrite=0. Returns to IDLE at k+2. memSelect is unchanged.
- LDR (op=01):
  - Cycle k+1: state READ, ramRe=1, ramAddr=memAddr, memSelect=1, busy=1. Wait counter loaded with RAM_LAT-1.
  - State WAIT then decrements the counter once per cycle; WAIT is skipped when RAM_LAT=1.
  - Cycle k+1+RAM_LAT: state WB with regWrite=1, memSelect=1, regDest=destReg, done=1.
  - Returns to IDLE the following cycle.
- Reserved (op=11): at cycle k+1, done=1, illegal=1, no RAM or register activity. Returns to IDLE.
- memSelect holds its last value between operations. It changes only on an ALU WB cycle (to 0) or in the LDR READ cycle (to 1), so it is stable throughout any regWrite pulse.
- ramAddr, ramWrData and regDest hold their last values when idle.
- start while busy=1: ignored and raises stall; the request must be held by the requester.
  - start in the done cycle is also ignored; the earliest new acceptance is the cycle after done.
  - Maximum throughput is one operation per 2 cycles.
- ramWe and ramRe are never high together. Neither strobe is ever high in the same cycle as regWrite.
- RAM_LAT outside 1..15 is a configuration error and must be flagged at elaboration.

Test Plan:
- Reset then idle: rst_n low for 3 cycles with start toggling -> all outputs 0, no strobes; release with start=0 -> outputs remain 0.
- ALU writeback: start, op=00, destReg=5 at edge k -> at k+1 regWrite=1, memSelect=0, regDest=5, done=1; at k+2 busy=0.
- Load, RAM_LAT=2: start, op=01, memAddr=0x3C, destReg=9 -> k+1 ramRe=1, ramAddr=0x3C, memSelect=1; k+2 no strobes; k+3 regWrite=1, regDest=9, done=1. Repeat with RAM_LAT=1 -> writeback at k+2.
- Store: op=10, memAddr=0x10, storeData=0xDEADBEEF -> k+1 ramWe=1, ramAddr=0x10, ramWrData=0xDEADBEEF, regWrite=0, done=1.
- Busy/stall: LDR accepted, then start held high with op=00 -> stall=1 through the LDR done cycle; ALU op accepted on the following edge; exactly one regWrite per operation.
- Reset mid-load: rst_n low at k+2 of an LDR -> outputs cleared immediately, no regWrite afterwards. op=11 separately -> done=1, illegal=1, no strobes.
